// File: rtl/ife_pkg.sv
// Shared types and constants for the instruction-block front end.
// Blocks carry four 32-bit instructions, slot 0 in the most significant word.
package ife_pkg;
    localparam int INSTR_W         = 32;
    localparam int SLOTS_PER_BLOCK = 4;
    localparam int BLOCK_W         = 128;
    localparam int ID_MAX_W        = 16;

    // ID field is sized for the widest tag in use; narrower IDs are zero-extended.
    typedef struct packed {
        logic [BLOCK_W-1:0]  data;
        logic [ID_MAX_W-1:0] id;
    } block_t;

    typedef enum logic {EMPTY = 1'b0, ISSUE = 1'b1} out_state_e;

    function automatic logic [INSTR_W-1:0] slot_word(input logic [BLOCK_W-1:0] data,
                                                     input logic [1:0]         slot);
        return data[(SLOTS_PER_BLOCK-1-int'(slot))*INSTR_W +: INSTR_W];
    endfunction
endpackage

// File: rtl/block_fifo.sv
// Generic circular-buffer FIFO with synchronous flush; read data is the
// current head, valid whenever empty is low.
module block_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/block_ingress_unpacker.sv
// Buffers incoming instruction blocks and issues them one instruction per
// cycle in program order over a valid/ready handshake.
module block_ingress_unpacker
    import ife_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int ID_W  = 7,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] block_data_in,
    input  logic [ID_W-1:0]    block_id_in,
    input  logic               block_valid_in,
    output logic               block_ready_out,
    input  logic               flush_in,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ID_W-1:0]    instr_id,
    output logic [1:0]         instr_slot,
    output logic               instr_last,
    output logic [CW-1:0]      fifo_count
);
    block_t     fifo_in, fifo_out, blk_q;
    logic       full, empty, push, pop, hs;
    out_state_e state_q, state_d;
    logic [1:0] slot_q, slot_d;

    // Ready never looks at valid, so the source may wait on it freely.
    assign block_ready_out = !full && !flush_in;
    assign push            = block_valid_in && block_ready_out;
    assign fifo_in         = '{data: block_data_in, id: ID_MAX_W'(block_id_in)};

    block_fifo #(.DEPTH(DEPTH), .WIDTH($bits(block_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_in),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_in),
        .rdata (fifo_out),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign instr_valid = (state_q == ISSUE);
    assign hs          = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        pop     = 1'b0;
        if (flush_in) begin
            state_d = EMPTY;
            slot_d  = '0;
        end else begin
            case (state_q)
                EMPTY: if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                    slot_d  = '0;
                end
                ISSUE: if (hs) begin
                    if (slot_q != 2'd3) begin
                        slot_d = slot_q + 2'd1;
                    end else if (!empty) begin
                        // Reload straight from the head so blocks issue back to back.
                        pop    = 1'b1;
                        slot_d = '0;
                    end else begin
                        state_d = EMPTY;
                        slot_d  = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            slot_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (pop) blk_q <= fifo_out;
        end
    end

    assign instr_data = slot_word(blk_q.data, slot_q);
    assign instr_id   = blk_q.id[ID_W-1:0];
    assign instr_slot = slot_q;
    assign instr_last = (slot_q == 2'd3);
endmodule
